// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one word load/store with fixed wait states,
// pipeline stall while busy, and error pulse for misaligned/out-of-range accesses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRd_i,
  input  logic        MemWr_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] addr_q, wdata_q;
  logic        wr_q, both_q, err_q;
  logic        req, commit, bad_addr;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS];

  assign req      = MemRd_i | MemWr_i;
  assign idx      = addr_q[AW+1:2];
  assign bad_addr = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH_WORDS));
  assign commit   = (state == BUSY) && (cnt == 4'd0);

  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    done_o    = 1'b0;
    err_o     = 1'b0;
    case (state)
      IDLE: begin
        stall_o = req;
        if (req) state_nxt = BUSY;
      end
      BUSY: begin
        stall_o = 1'b1;
        if (cnt == 4'd0) state_nxt = DONE;
      end
      DONE: begin
        // requests seen here belong to the instruction that is retiring now
        done_o    = 1'b1;
        err_o     = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_o <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req) begin
          addr_q  <= addr_i;
          wdata_q <= wdata_i;
          wr_q    <= MemWr_i;
          both_q  <= MemRd_i & MemWr_i;
          cnt     <= 4'(WAIT_CYCLES - 1);
        end
        BUSY: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else begin
            err_q <= bad_addr | both_q;
            if (!wr_q) rdata_o <= bad_addr ? 32'd0 : mem[idx];
          end
        end
        default: ;
      endcase
    end
  end

  // array is never cleared; reset on the commit edge suppresses the write
  always_ff @(posedge clk_i) begin
    if (!rst_i && commit && wr_q && !bad_addr) mem[idx] <= wdata_q;
  end
endmodule
